// File: rtl/mem_ctrl_arbiter.sv
// rtl/mem_ctrl_arbiter.sv - byte-wide RAM port sequencer shared by instruction fetch and load/store
// Optional IO_STALL_EN: holds I/O-region stores (addr[17:16] = 2'b11) while io_buffer_full is high.
module mem_ctrl_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              IF_req,
  input  logic [ADDR_W-1:0] IF_addr,
  output logic              IF_done,
  output logic [DATA_W-1:0] IF_data,
  input  logic              LS_req,
  input  logic              LS_we,
  input  logic [1:0]        LS_size,
  input  logic [ADDR_W-1:0] LS_addr,
  input  logic [DATA_W-1:0] LS_wdata,
  output logic              LS_done,
  output logic [DATA_W-1:0] LS_rdata,
  input  logic              roll_back,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {IDLE, READ_IF, READ_LS, WRITE_LS} state_t;
  typedef enum logic {GRANT_IF, GRANT_LS} grant_t;

  state_t            state, state_n;
  grant_t            last_grant, last_grant_n;
  logic [2:0]        cnt, cnt_n;
  logic [2:0]        len, len_n;
  logic [2:0]        ls_len;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] rd_buf, rd_buf_n, rd_merge;
  logic [DATA_W-1:0] if_data_n, ls_rdata_n;
  logic [ADDR_W-1:0] mem_a_n;
  logic [7:0]        mem_dout_n;
  logic              mem_wr_n, if_done_n, ls_done_n;
  logic [1:0]        byte_idx;
  logic              io_block, if_ok, ls_ok, pick_ls;

`ifdef IO_STALL_EN
  assign io_block = LS_we && (LS_addr[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full;
  assign io_block = 1'b0;
`endif

  // A requester whose done pulse is still high is masked for one cycle.
  assign if_ok   = IF_req && !IF_done;
  assign ls_ok   = LS_req && !LS_done && !io_block;
  assign pick_ls = ls_ok && (!if_ok || (last_grant == GRANT_IF));

  always_comb begin
    ls_len = 3'd4;
    case (LS_size)
      2'b00:   ls_len = 3'd1;
      2'b01:   ls_len = 3'd2;
      default: ls_len = 3'd4;
    endcase
  end

  // Byte k arrives two edges after its address, i.e. when cnt = k + 1.
  always_comb begin
    byte_idx = cnt[1:0] - 2'd1;
    rd_merge = rd_buf;
    rd_merge[{byte_idx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    len_n        = len;
    wdata_n      = wdata_q;
    rd_buf_n     = rd_buf;
    if_data_n    = IF_data;
    ls_rdata_n   = LS_rdata;
    mem_a_n      = mem_a;
    mem_dout_n   = mem_dout;
    mem_wr_n     = 1'b0;
    if_done_n    = 1'b0;
    ls_done_n    = 1'b0;

    case (state)
      IDLE: begin
        if (!roll_back) begin
          if (pick_ls) begin
            last_grant_n = GRANT_LS;
            mem_a_n      = LS_addr;
            len_n        = ls_len;
            cnt_n        = 3'd0;
            if (LS_we) begin
              mem_wr_n   = 1'b1;
              mem_dout_n = LS_wdata[7:0];
              wdata_n    = LS_wdata;
              if (ls_len == 3'd1) begin
                ls_done_n = 1'b1;
              end else begin
                state_n = WRITE_LS;
                cnt_n   = 3'd1;
              end
            end else begin
              rd_buf_n = '0;
              state_n  = READ_LS;
            end
          end else if (if_ok) begin
            last_grant_n = GRANT_IF;
            mem_a_n      = IF_addr;
            len_n        = 3'd4;
            cnt_n        = 3'd0;
            rd_buf_n     = '0;
            state_n      = READ_IF;
          end
        end
      end

      READ_IF, READ_LS: begin
        if (roll_back) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
        end else begin
          if ((cnt + 3'd1) < len) mem_a_n = mem_a + ADDR_W'(1);
          if (cnt != 3'd0) rd_buf_n = rd_merge;
          if (cnt == len) begin
            state_n = IDLE;
            cnt_n   = 3'd0;
            if (state == READ_IF) begin
              if_done_n = 1'b1;
              if_data_n = rd_merge;
            end else begin
              ls_done_n  = 1'b1;
              ls_rdata_n = rd_merge;
            end
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end

      // Stores are committed work, so roll_back does not stop them.
      WRITE_LS: begin
        mem_wr_n   = 1'b1;
        mem_a_n    = mem_a + ADDR_W'(1);
        mem_dout_n = wdata_q[{cnt[1:0], 3'b000} +: 8];
        if (cnt == (len - 3'd1)) begin
          ls_done_n = 1'b1;
          state_n   = IDLE;
          cnt_n     = 3'd0;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_IF;
      cnt        <= 3'd0;
      len        <= 3'd0;
      wdata_q    <= '0;
      rd_buf     <= '0;
      IF_data    <= '0;
      LS_rdata   <= '0;
      IF_done    <= 1'b0;
      LS_done    <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= 8'h00;
      mem_wr     <= 1'b0;
    end else if (rdy) begin
      state      <= state_n;
      last_grant <= last_grant_n;
      cnt        <= cnt_n;
      len        <= len_n;
      wdata_q    <= wdata_n;
      rd_buf     <= rd_buf_n;
      IF_data    <= if_data_n;
      LS_rdata   <= ls_rdata_n;
      IF_done    <= if_done_n;
      LS_done    <= ls_done_n;
      mem_a      <= mem_a_n;
      mem_dout   <= mem_dout_n;
      mem_wr     <= mem_wr_n;
    end else begin
      mem_wr <= 1'b0;
    end
  end

endmodule
